// File: rtl/line_mem_responder.sv
// Memory-side responder for the 128-bit cache line protocol: a line array with
// programmable read latency, fronted by a single-entry posted write buffer.
module line_mem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int RD_LAT     = 8,
    parameter int WR_LAT     = 8
) (
    input  logic         clk,
    input  logic         proc_reset,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [27:0]  mem_addr,
    input  logic [127:0] mem_wdata,
    output logic [127:0] mem_rdata,
    output logic         mem_ready,
    output logic         wbuf_busy,
    output logic         proto_err
);

    localparam int         DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [7:0] RD_LOAD = 8'(RD_LAT - 1);
    localparam logic [7:0] WR_LOAD = 8'(WR_LAT - 1);

    if (RD_LAT < 1 || RD_LAT > 255) begin : g_bad_rd_lat
        $error("line_mem_responder: RD_LAT must be in 1..255");
    end
    if (WR_LAT < 1 || WR_LAT > 255) begin : g_bad_wr_lat
        $error("line_mem_responder: WR_LAT must be in 1..255");
    end

    typedef enum logic [2:0] {IDLE, RD_WAIT, WR_WAIT, RESP, GAP} req_state_t;
    typedef enum logic {DR_IDLE, DR_BUSY} dr_state_t;

    logic [127:0] mem [DEPTH];

    req_state_t   req_state_q, req_state_d;
    dr_state_t    dr_state_q, dr_state_d;
    logic [7:0]   rd_cnt_q, rd_cnt_d;
    logic [7:0]   wr_cnt_q, wr_cnt_d;
    logic         buf_valid_q, buf_valid_d;
    logic [27:0]  buf_addr_q, buf_addr_d;
    logic [127:0] buf_data_q, buf_data_d;
    logic         proto_err_q, proto_err_d;
    logic [127:0] rdata_q;

    logic drain_done;
    logic capture;
    logic rd_fwd;
    logic rd_arr;
    logic mem_we;

    assign drain_done = (dr_state_q == DR_BUSY) && (wr_cnt_q == 8'd0);
    assign mem_we     = drain_done && !proc_reset;

    // Request FSM. rd_cnt holds the cycles still to go before mem_ready, so the
    // array is read when one cycle remains and RESP lands RD_LAT after acceptance.
    always_comb begin
        req_state_d = req_state_q;
        rd_cnt_d    = rd_cnt_q;
        proto_err_d = proto_err_q;
        capture     = 1'b0;
        rd_fwd      = 1'b0;
        rd_arr      = 1'b0;
        case (req_state_q)
            IDLE: begin
                if (mem_write) begin
                    if (mem_read) begin
                        proto_err_d = 1'b1;
                    end
                    if (!buf_valid_q || drain_done) begin
                        capture     = 1'b1;
                        req_state_d = RESP;
                    end else begin
                        req_state_d = WR_WAIT;
                    end
                end else if (mem_read) begin
                    if (buf_valid_q && (buf_addr_q == mem_addr)) begin
                        rd_fwd      = 1'b1;
                        req_state_d = RESP;
                    end else if ((RD_LAT == 1) && !buf_valid_q) begin
                        rd_arr      = 1'b1;
                        req_state_d = RESP;
                    end else begin
                        rd_cnt_d    = RD_LOAD;
                        req_state_d = RD_WAIT;
                    end
                end
            end
            WR_WAIT: begin
                if (!buf_valid_q || drain_done) begin
                    capture     = 1'b1;
                    req_state_d = RESP;
                end
            end
            RD_WAIT: begin
                // Holding while the buffer is valid keeps reads behind any pending write.
                if (!buf_valid_q) begin
                    if (rd_cnt_q <= 8'd1) begin
                        rd_arr      = 1'b1;
                        req_state_d = RESP;
                    end else begin
                        rd_cnt_d = rd_cnt_q - 8'd1;
                    end
                end
            end
            RESP:    req_state_d = GAP;
            GAP:     req_state_d = IDLE;
            default: req_state_d = IDLE;
        endcase
    end

    // Drain FSM; a capture on the drain's final cycle refills the buffer while
    // the old line is written to the array on the same edge.
    always_comb begin
        dr_state_d  = dr_state_q;
        wr_cnt_d    = wr_cnt_q;
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        if (capture) begin
            buf_valid_d = 1'b1;
            buf_addr_d  = mem_addr;
            buf_data_d  = mem_wdata;
            dr_state_d  = DR_BUSY;
            wr_cnt_d    = WR_LOAD;
        end else if (dr_state_q == DR_BUSY) begin
            if (wr_cnt_q == 8'd0) begin
                buf_valid_d = 1'b0;
                dr_state_d  = DR_IDLE;
            end else begin
                wr_cnt_d = wr_cnt_q - 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            req_state_q <= IDLE;
            dr_state_q  <= DR_IDLE;
            rd_cnt_q    <= 8'd0;
            wr_cnt_q    <= 8'd0;
            buf_valid_q <= 1'b0;
            buf_addr_q  <= 28'd0;
            buf_data_q  <= 128'd0;
            proto_err_q <= 1'b0;
        end else begin
            req_state_q <= req_state_d;
            dr_state_q  <= dr_state_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            proto_err_q <= proto_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[buf_addr_q[DEPTH_LOG2-1:0]] <= buf_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            rdata_q <= 128'd0;
        end else if (rd_fwd) begin
            rdata_q <= buf_data_q;
        end else if (rd_arr) begin
            rdata_q <= mem[mem_addr[DEPTH_LOG2-1:0]];
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_ready = (req_state_q == RESP);
    assign wbuf_busy = buf_valid_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder: read latency, posted writes, forwarding,
// read ordering behind a drain, aliasing, protocol error and reset mid-drain.
module tb_line_mem_responder;

    logic         clk;
    logic         proc_reset;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
    logic         wbuf_busy;
    logic         proto_err;

    int tests = 0;
    int fails = 0;

    line_mem_responder #(
        .DEPTH_LOG2(10),
        .RD_LAT    (8),
        .WR_LAT    (8)
    ) dut (
        .clk       (clk),
        .proc_reset(proc_reset),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .wbuf_busy (wbuf_busy),
        .proto_err (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] P5 = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] P7 = 128'h77777777_00000007_77777777_00000007;
    localparam logic [127:0] P9 = 128'h99999999_00000009_99999999_00000009;
    localparam logic [127:0] DA = 128'hAAAA0001_AAAA0002_AAAA0003_AAAA0004;
    localparam logic [127:0] DB = 128'hBBBB0001_BBBB0002_BBBB0003_BBBB0004;
    localparam logic [127:0] DC = 128'hCCCC0001_CCCC0002_CCCC0003_CCCC0004;
    localparam logic [127:0] DD = 128'hDDDD0001_DDDD0002_DDDD0003_DDDD0004;
    localparam logic [127:0] DE = 128'hEEEE0001_EEEE0002_EEEE0003_EEEE0004;
    localparam logic [127:0] DF = 128'hFFFF0001_FFFF0002_FFFF0003_FFFF0004;
    localparam logic [127:0] DG = 128'h66660001_66660002_66660003_66660004;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("[TB] check %-16s observed %h expected %h", tag, obs, exp);
    endtask

    // Called at a negedge with the FSM idle; returns at a negedge with it idle again.
    task automatic req(input logic rd, input logic wr, input logic [27:0] addr,
                       input logic [127:0] wd, output int lat,
                       output logic [127:0] rdo, output logic busy);
        bit got;
        got = 1'b0;
        lat = 0;
        rdo = '0;
        busy = 1'b0;
        mem_read = rd;
        mem_write = wr;
        mem_addr = addr;
        mem_wdata = wd;
        while (!got && lat < 400) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (mem_ready) got = 1'b1;
        end
        tests++;
        if (!got) begin
            fails++;
            $error("FAIL req_timeout: observed no mem_ready after %0d cycles, required a pulse", lat);
        end
        rdo = mem_rdata;
        busy = wbuf_busy;
        mem_read = 1'b0;
        mem_write = 1'b0;
        $display("[TB] req rd=%0b wr=%0b addr=%h lat=%0d rdata=%h busy=%0b", rd, wr, addr, lat, rdo, busy);
        @(posedge clk);
        @(negedge clk);
        chk("ready_one_cycle", 128'(mem_ready), 128'd0);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (wbuf_busy && n < 100) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        tests++;
        if (wbuf_busy) begin
            fails++;
            $error("FAIL drain_timeout: observed wbuf_busy=1 after %0d cycles, required 0", n);
        end
    endtask

    initial begin
        int           lat;
        logic [127:0] rdo;
        logic         busy;

        proc_reset = 1'b1;
        mem_read = 1'b0;
        mem_write = 1'b0;
        mem_addr = '0;
        mem_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        proc_reset = 1'b0;
        chk("rst_ready", 128'(mem_ready), 128'd0);
        chk("rst_rdata", mem_rdata, 128'd0);
        chk("rst_busy", 128'(wbuf_busy), 128'd0);
        chk("rst_proto", 128'(proto_err), 128'd0);

        dut.mem[5]  = P5;
        dut.mem[7]  = P7;
        dut.mem[9]  = P9;
        dut.mem[16] = 128'd0;

        // Plain read latency with an idle buffer
        req(1'b1, 1'b0, 28'd5, '0, lat, rdo, busy);
        chk("rd5_lat", 128'(lat), 128'd8);
        chk("rd5_data", rdo, P5);

        // Posted write then forwarded read
        req(1'b0, 1'b1, 28'h10, DA, lat, rdo, busy);
        chk("wrA_lat", 128'(lat), 128'd1);
        chk("wrA_busy", 128'(busy), 128'd1);
        chk("wrA_rdata_kept", rdo, P5);
        req(1'b1, 1'b0, 28'h10, '0, lat, rdo, busy);
        chk("fwdA_lat", 128'(lat), 128'd1);
        chk("fwdA_data", rdo, DA);
        chk("fwdA_busy", 128'(busy), 128'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("drainA_pending", dut.mem[16], 128'd0);
        chk("drainA_busy", 128'(wbuf_busy), 128'd1);
        @(posedge clk);
        @(negedge clk);
        chk("drainA_done", dut.mem[16], DA);
        chk("drainA_idle", 128'(wbuf_busy), 128'd0);

        // Read ordered behind a draining write
        req(1'b0, 1'b1, 28'd3, DB, lat, rdo, busy);
        chk("wrB_lat", 128'(lat), 128'd1);
        req(1'b1, 1'b0, 28'd7, '0, lat, rdo, busy);
        chk("rd7_lat", 128'(lat), 128'd13);
        chk("rd7_data", rdo, P7);
        req(1'b1, 1'b0, 28'd3, '0, lat, rdo, busy);
        chk("rd3_lat", 128'(lat), 128'd8);
        chk("rd3_data", rdo, DB);

        // Back-to-back writes
        req(1'b0, 1'b1, 28'd1, DC, lat, rdo, busy);
        chk("wrC_lat", 128'(lat), 128'd1);
        req(1'b0, 1'b1, 28'd2, DD, lat, rdo, busy);
        chk("wrD_lat", 128'(lat), 128'd6);
        req(1'b1, 1'b0, 28'd1, '0, lat, rdo, busy);
        chk("rd1_data", rdo, DC);
        req(1'b1, 1'b0, 28'd2, '0, lat, rdo, busy);
        chk("rd2_data", rdo, DD);

        // Aliasing and protocol error
        wait_idle();
        chk("proto_clear", 128'(proto_err), 128'd0);
        req(1'b0, 1'b1, 28'h400, DF, lat, rdo, busy);
        req(1'b1, 1'b0, 28'h000, '0, lat, rdo, busy);
        chk("alias_data", rdo, DF);
        req(1'b1, 1'b1, 28'h20, DG, lat, rdo, busy);
        chk("both_lat", 128'(lat), 128'd1);
        chk("both_rdata_kept", rdo, DF);
        chk("proto_set", 128'(proto_err), 128'd1);
        req(1'b1, 1'b0, 28'h20, '0, lat, rdo, busy);
        chk("both_wrote", rdo, DG);
        chk("proto_sticky", 128'(proto_err), 128'd1);

        // Reset while a write is draining
        wait_idle();
        req(1'b0, 1'b1, 28'd9, DE, lat, rdo, busy);
        proc_reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        proc_reset = 1'b0;
        chk("mid_rst_ready", 128'(mem_ready), 128'd0);
        chk("mid_rst_rdata", mem_rdata, 128'd0);
        chk("mid_rst_busy", 128'(wbuf_busy), 128'd0);
        chk("mid_rst_proto", 128'(proto_err), 128'd0);
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("mid_rst_array", dut.mem[9], P9);
        req(1'b1, 1'b0, 28'd9, '0, lat, rdo, busy);
        chk("rd9_lat", 128'(lat), 128'd8);
        chk("rd9_data", rdo, P9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
